// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int ADDR_LEN             = 32;
  localparam int INST_LEN             = 32;
  localparam int ICACHE_LINES_DEFAULT = 128;
  localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

  function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache of one-word lines with per-line valid bits.
// Combinational lookup; a line is written on the clock edge when we is high.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] lookup_addr,
  output logic                hit,
  output logic [INST_LEN-1:0] rdata,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [INST_LEN-1:0] wdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_LEN - IDX_W - 2;

  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];
  logic [IDX_W-1:0]    lookup_idx;
  logic [IDX_W-1:0]    write_idx;
  logic                unused_low;

  assign lookup_idx = lookup_addr[IDX_W+1:2];
  assign write_idx  = waddr[IDX_W+1:2];
  assign hit        = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_addr[ADDR_LEN-1:IDX_W+2]);
  assign rdata      = data_mem[lookup_idx];
  assign unused_low = ^{lookup_addr[1:0], waddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[write_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data storage is never reset; the valid bits alone qualify every line.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[write_idx]  <= waddr[ADDR_LEN-1:IDX_W+2];
      data_mem[write_idx] <= wdata;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit word from four byte reads and holds it for decode.
// Define ICACHE_EN to add a direct-mapped instruction cache in front of the byte bus.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_LEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                  ICACHE_LINES = ICACHE_LINES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                jump_i,
  input  logic [ADDR_LEN-1:0] jump_addr_i,
  input  logic                mem_gnt_i,
  input  logic [7:0]          mem_rdata_i,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [INST_LEN-1:0] inst_o,
  output logic                inst_valid_o
);

  if_state_e           state;
  if_state_e           state_next;
  logic [ADDR_LEN-1:0] pc;
  logic [2:0]          issue_cnt;
  logic [2:0]          recv_cnt;
  logic                pending;
  logic                grant;
  logic                last_byte;
  logic                handoff;
  logic                lookup_en;
  logic                cache_hit;
  logic [INST_LEN-1:0] cache_rdata;

  assign grant     = mem_req_o && mem_gnt_i;
  assign last_byte = (state == IF_FETCH) && pending && (recv_cnt == 3'd3);
  assign handoff   = (state == IF_HOLD) && !stall_i;
  assign lookup_en = (state == IF_IDLE) || handoff;

`ifdef ICACHE_EN
  logic [ADDR_LEN-1:0] lookup_addr;
  logic                cache_hit_raw;
  logic                fill_we;

  // At a handoff the line of interest is the one after the instruction being held.
  assign lookup_addr = (state == IF_HOLD) ? pc + 32'd4 : pc;
  assign fill_we     = last_byte && !jump_i;
  assign cache_hit   = lookup_en && cache_hit_raw && !jump_i;

  if_fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(lookup_addr),
    .hit        (cache_hit_raw),
    .rdata      (cache_rdata),
    .we         (fill_we),
    .waddr      (pc),
    .wdata      ({mem_rdata_i, inst_o[23:0]})
  );
`else
  logic unused_cfg;

  assign cache_hit   = 1'b0;
  assign cache_rdata = ZERO_WORD;
  assign unused_cfg  = lookup_en ^ (ICACHE_LINES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IF_IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_next = state;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    unique case (state)
      IF_IDLE:  state_next = cache_hit ? IF_HOLD : IF_FETCH;
      IF_FETCH: begin
        mem_req_o  = (issue_cnt < 3'd4);
        mem_addr_o = pc + ADDR_LEN'(issue_cnt);
        if (last_byte) state_next = IF_HOLD;
      end
      IF_HOLD:  if (!stall_i) state_next = cache_hit ? IF_HOLD : IF_FETCH;
      default:  state_next = IF_IDLE;
    endcase
    if (jump_i) state_next = IF_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      pc_o         <= RESET_PC;
      inst_o       <= ZERO_WORD;
      inst_valid_o <= 1'b0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      pending      <= 1'b0;
    end else if (jump_i) begin
      pc           <= word_align(jump_addr_i);
      inst_valid_o <= 1'b0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      pending      <= 1'b0;
    end else begin
      unique case (state)
        IF_IDLE: begin
          if (cache_hit) begin
            inst_o       <= cache_rdata;
            pc_o         <= pc;
            inst_valid_o <= 1'b1;
          end
        end
        IF_FETCH: begin
          pending <= grant;
          if (grant) issue_cnt <= issue_cnt + 3'd1;
          if (pending) begin
            inst_o[{recv_cnt[1:0], 3'b000} +: 8] <= mem_rdata_i;
            recv_cnt <= recv_cnt + 3'd1;
            if (recv_cnt == 3'd3) begin
              inst_valid_o <= 1'b1;
              pc_o         <= pc;
            end
          end
        end
        IF_HOLD: begin
          if (!stall_i) begin
            pc        <= pc + 32'd4;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= 1'b0;
            if (cache_hit) begin
              inst_o <= cache_rdata;
              pc_o   <= pc + 32'd4;
            end else begin
              inst_valid_o <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte-memory model, directed scenarios and a randomized run
// checked against a transaction-level model of the fetched pc/instruction stream.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [4096];
  logic [7:0]  rdata_q;
  logic [31:0] gnt_log [$];
  int          req_cycles = 0;

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  // Byte memory: data is valid exactly one cycle after a grant, garbage otherwise.
  assign mem_rdata_i = rdata_q;
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) begin
      rdata_q <= mem[mem_addr_o[11:0]];
      gnt_log.push_back(mem_addr_o);
    end else begin
      rdata_q <= 8'($urandom);
    end
    if (mem_req_o) req_cycles <= req_cycles + 1;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] b;
    b = a & 32'hFFFF_FFFC;
    return {mem[12'(b + 32'd3)], mem[12'(b + 32'd2)], mem[12'(b + 32'd1)], mem[12'(b)]};
  endfunction

  function automatic bit addrs_ok(input int base, input logic [31:0] start);
    if (gnt_log.size() != base + 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (gnt_log[base + i] !== start + 32'(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit tail_ok(input int base, input logic [31:0] start);
    int sz;
    sz = gnt_log.size();
    if (sz < base + 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (gnt_log[sz - 4 + i] !== start + 32'(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] first_since(input int base);
    if (gnt_log.size() > base) return gnt_log[base];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; jump_i = 1'b0; stall_i = 1'b1; mem_gnt_i = 1'b1; jump_addr_i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick(); n++;
      if (inst_valid_o === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h40; stall_i = 1'b0; mem_gnt_i = 1'b1;
    tick(); tick();
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", inst_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    jump_i = 1'b0; stall_i = 1'b1;
  endtask

  task automatic test_first_fetch();
    int base, n;
    base = gnt_log.size();
    rst = 1'b0;
    wait_valid(50, n);
    total++; if (n != 6) begin bad++; $display("FAIL first_latency: got %0d want 6", n); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL first_pc: got %h want 0", pc_o); end
    total++; if (inst_o !== 32'h0050_0513) begin bad++; $display("FAIL first_inst: got %h want 00500513", inst_o); end
    total++; if (!addrs_ok(base, 32'h0)) begin
      bad++; $display("FAIL first_addrs: got %0d grants from %h want 4 from 0", gnt_log.size() - base, first_since(base));
    end
  endtask

  task automatic test_grant_gaps();
    int base, n;
    do_reset();
    base = gnt_log.size(); n = 0;
    while (n < 60 && inst_valid_o !== 1'b1) begin
      mem_gnt_i = (n >= 3 && n < 6) ? 1'b0 : 1'b1;
      tick(); n++;
    end
    mem_gnt_i = 1'b1;
    total++; if (n != 9) begin bad++; $display("FAIL gap_latency: got %0d want 9", n); end
    total++; if (inst_o !== word_at(0)) begin bad++; $display("FAIL gap_inst: got %h want %h", inst_o, word_at(0)); end
    total++; if (!addrs_ok(base, 32'h0)) begin
      bad++; $display("FAIL gap_addrs: got %0d grants from %h want 4 from 0", gnt_log.size() - base, first_since(base));
    end
  endtask

  task automatic test_random_grants();
    for (int it = 0; it < 4; it++) begin
      bit g [64];
      int grants, exp_n, n, base;
      for (int k = 0; k < 64; k++) g[k] = (k >= 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
      grants = 0; exp_n = -1;
      for (int k = 2; k < 64; k++) begin
        if (g[k]) grants++;
        if (grants == 4) begin exp_n = k + 1; break; end
      end
      do_reset();
      base = gnt_log.size(); n = 0;
      while (n < 63 && inst_valid_o !== 1'b1) begin
        mem_gnt_i = g[n + 1];
        tick(); n++;
      end
      mem_gnt_i = 1'b1;
      total++; if (n != exp_n) begin bad++; $display("FAIL rgnt_latency[%0d]: got %0d want %0d", it, n, exp_n); end
      total++; if (inst_o !== word_at(0)) begin bad++; $display("FAIL rgnt_inst[%0d]: got %h want %h", it, inst_o, word_at(0)); end
      total++; if (!addrs_ok(base, 32'h0)) begin
        bad++; $display("FAIL rgnt_addrs[%0d]: got %0d grants from %h", it, gnt_log.size() - base, first_since(base));
      end
    end
  endtask

  task automatic test_stall();
    int r0, base, n;
    r0 = req_cycles;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, inst_valid_o); end
      total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL stall_pc[%0d]: got %h want 0", c, pc_o); end
      total++; if (inst_o !== word_at(0)) begin bad++; $display("FAIL stall_inst[%0d]: got %h want %h", c, inst_o, word_at(0)); end
    end
    total++; if (req_cycles != r0) begin bad++; $display("FAIL stall_req: got %0d request cycles want 0", req_cycles - r0); end
    base = gnt_log.size();
    stall_i = 1'b0; tick(); stall_i = 1'b1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL handoff_valid: got %b want 0", inst_valid_o); end
    wait_valid(50, n);
    total++; if (n != 5) begin bad++; $display("FAIL handoff_latency: got %0d want 5", n); end
    total++; if (pc_o !== 32'h4) begin bad++; $display("FAIL handoff_pc: got %h want 4", pc_o); end
    total++; if (inst_o !== word_at(4)) begin bad++; $display("FAIL handoff_inst: got %h want %h", inst_o, word_at(4)); end
    total++; if (!addrs_ok(base, 32'h4)) begin
      bad++; $display("FAIL handoff_addrs: got %0d grants from %h want 4 from 4", gnt_log.size() - base, first_since(base));
    end
  endtask

  task automatic test_jump_mid();
    int base, n, k;
    stall_i = 1'b0; tick(); stall_i = 1'b1;
    k = 0;
    while (k < 10 && !(mem_req_o === 1'b1 && mem_addr_o === 32'hA)) begin tick(); k++; end
    total++; if (k >= 10) begin bad++; $display("FAIL jmid_reach: got timeout want byte-2 request at a"); end
    jump_i = 1'b1; jump_addr_i = 32'h103;
    tick();
    jump_i = 1'b0;
    base = gnt_log.size();
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL jmid_valid: got %b want 0", inst_valid_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL jmid_idle_req: got %b want 0", mem_req_o); end
    wait_valid(50, n);
    total++; if (n != 6) begin bad++; $display("FAIL jmid_latency: got %0d want 6", n); end
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL jmid_pc: got %h want 100", pc_o); end
    total++; if (inst_o !== word_at(32'h100)) begin bad++; $display("FAIL jmid_inst: got %h want %h", inst_o, word_at(32'h100)); end
    total++; if (!addrs_ok(base, 32'h100)) begin
      bad++; $display("FAIL jmid_addrs: got %0d grants from %h want 4 from 100", gnt_log.size() - base, first_since(base));
    end
  endtask

  task automatic test_jump_hold();
    int base, n;
    base = gnt_log.size();
    stall_i = 1'b0; jump_i = 1'b1; jump_addr_i = 32'hA46;
    tick();
    jump_i = 1'b0; stall_i = 1'b1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL jhold_valid: got %b want 0", inst_valid_o); end
    wait_valid(50, n);
    total++; if (n != 6) begin bad++; $display("FAIL jhold_latency: got %0d want 6", n); end
    total++; if (pc_o !== 32'hA44) begin bad++; $display("FAIL jhold_pc: got %h want a44", pc_o); end
    total++; if (inst_o !== word_at(32'hA44)) begin bad++; $display("FAIL jhold_inst: got %h want %h", inst_o, word_at(32'hA44)); end
    total++; if (!addrs_ok(base, 32'hA44)) begin
      bad++; $display("FAIL jhold_addrs: got %0d grants from %h want 4 from a44", gnt_log.size() - base, first_since(base));
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    stall_i = 1'b0; tick(); stall_i = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", inst_valid_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rmid_req: got %b want 0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rmid_addr: got %h want 0", mem_addr_o); end
    rst = 1'b0;
    base = gnt_log.size();
    wait_valid(50, n);
    total++; if (n != 6) begin bad++; $display("FAIL rmid_latency: got %0d want 6", n); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rmid_pc: got %h want 0", pc_o); end
    total++; if (inst_o !== word_at(0)) begin bad++; $display("FAIL rmid_inst: got %h want %h", inst_o, word_at(0)); end
    total++; if (!addrs_ok(base, 32'h0)) begin
      bad++; $display("FAIL rmid_addrs: got %0d grants from %h want 4 from 0", gnt_log.size() - base, first_since(base));
    end
  endtask

`ifdef ICACHE_EN
  task automatic test_icache();
    int r0, n;
    do_reset();
    wait_valid(50, n);
    r0 = req_cycles;
    jump_i = 1'b1; jump_addr_i = 32'h0;
    tick();
    jump_i = 1'b0;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL ic_idle_valid: got %b want 0", inst_valid_o); end
    tick();
    total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL ic_hit_valid: got %b want 1", inst_valid_o); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL ic_hit_pc: got %h want 0", pc_o); end
    total++; if (inst_o !== word_at(0)) begin bad++; $display("FAIL ic_hit_inst: got %h want %h", inst_o, word_at(0)); end
    total++; if (req_cycles != r0) begin bad++; $display("FAIL ic_hit_req: got %0d request cycles want 0", req_cycles - r0); end
    do_reset();
    wait_valid(50, n);
    total++; if (n != 6) begin bad++; $display("FAIL ic_miss_after_rst: got %0d want 6", n); end
  endtask
`endif

  // Randomized run: the model only tracks which pc must be presented next.
  task automatic test_random();
    logic [31:0] exp_pc;
    int presented, base, since;
    bit prev_valid, handoff_prev;
    do_reset();
    exp_pc = 32'h0; presented = 0; since = 0;
    prev_valid = 1'b0; handoff_prev = 1'b0;
    base = gnt_log.size();
    for (int c = 0; c < 6000 && presented < 40; c++) begin
      if (inst_valid_o === 1'b1 && (!prev_valid || handoff_prev)) begin
        total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", presented, pc_o, exp_pc); end
        total++; if (inst_o !== word_at(exp_pc)) begin
          bad++; $display("FAIL rnd_inst[%0d]: got %h want %h", presented, inst_o, word_at(exp_pc));
        end
`ifndef ICACHE_EN
        total++; if (!tail_ok(base, exp_pc)) begin
          bad++; $display("FAIL rnd_addrs[%0d]: got %0d grants want tail from %h", presented, gnt_log.size() - base, exp_pc);
        end
`endif
        base = gnt_log.size();
        presented++; since = 0;
      end
      since++;
      if (since > 200) begin
        total++; bad++;
        $display("FAIL rnd_timeout: got no instruction for 200 cycles want pc %h", exp_pc);
        break;
      end
      prev_valid   = (inst_valid_o === 1'b1);
      handoff_prev = 1'b0;
      mem_gnt_i    = ($urandom_range(0, 9) < 7);
      jump_i       = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        jump_i      = 1'b1;
        jump_addr_i = $urandom;
        exp_pc      = jump_addr_i & 32'hFFFF_FFFC;
        stall_i     = $urandom_range(0, 1) == 1;
      end else if (prev_valid) begin
        stall_i = ($urandom_range(0, 1) == 1);
        if (!stall_i) begin
          exp_pc       = exp_pc + 32'd4;
          handoff_prev = 1'b1;
        end
      end else begin
        stall_i = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    jump_i = 1'b0; stall_i = 1'b1; mem_gnt_i = 1'b1;
    total++; if (presented < 40) begin bad++; $display("FAIL rnd_count: got %0d want 40", presented); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
    test_reset();
    test_first_fetch();
    test_grant_gaps();
    test_stall();
    test_jump_mid();
    test_jump_hold();
    test_reset_mid();
    test_random_grants();
`ifdef ICACHE_EN
    test_icache();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that produces the `pc`/`inst` pair consumed by the decode stage.
- Fetches each 32-bit instruction as four byte reads over the shared byte-wide memory bus, arbitrated by mem_ctrl.
- Holds a fetched instruction while decode stalls.
- Redirects on branch/jump resolution from EX.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- ICACHE_LINES, 128: direct-mapped one-word lines. Power of two. Used only with ICACHE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  decode/ctrl stall; holds the presented instruction
- jump_i  in  1  one-cycle redirect pulse from EX
- jump_addr_i  in  32  redirect target; bits [1:0] treated as 0
- mem_gnt_i  in  1  arbiter accepted mem_addr_o this cycle
- mem_rdata_i  in  8  read byte, valid exactly one cycle after grant
- mem_req_o  out  1  byte read request
- mem_addr_o  out  32  byte address
- pc_o  out  32  PC of inst_o
- inst_o  out  32  fetched instruction, little-endian
- inst_valid_o  out  1  pc_o/inst_o valid for decode

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- State after a reset edge:
  - state=IDLE, pc=RESET_PC, inst_o=0, inst_valid_o=0.
  - mem_req_o=0, mem_addr_o=0, issue_cnt=0, recv_cnt=0, pending=0.
  - rst overrides every other input.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - Single bubble cycle; always goes to FETCH.
  - Cache lookup happens here when ICACHE_EN is defined.
- FETCH issue side:
  - mem_req_o = (issue_cnt<4); mem_addr_o = pc + issue_cnt.
  - issue_cnt increments on each mem_gnt_i && mem_req_o.
- FETCH receive side:
  - pending <= grant this cycle.
  - When pending, mem_rdata_i is written to inst byte recv_cnt (bits [8k+7:8k]), then recv_cnt increments.
  - When the 4th byte is captured: go to HOLD, inst_valid_o <= 1, pc_o <= pc.
- Latency: grant every cycle gives inst_valid_o 5 cycles after FETCH entry; 6 cycles counting IDLE. Denied grants add one cycle each.
- HOLD:
  - inst_valid_o=1; pc_o/inst_o stable.
  - stall_i=0 at the edge: handoff. pc <= pc+4 (32-bit wrap), inst_valid_o <= 0, go to FETCH, counters cleared.
  - stall_i=1: remain in HOLD.
- jump_i=1 (any state, overrides stall_i and handoff):
  - pc <= {jump_addr_i[31:2],2'b00}, inst_valid_o <= 0, go to IDLE, counters cleared.
  - A byte returning in the cycle after the jump (pending=1) is discarded: pending is cleared by the jump.
- Reset mid-fetch: partial bytes are dropped. mem_req_o is low in the cycle after reset.
- mem_req_o is never asserted in IDLE or HOLD.

Optional Feature:
- Macro: ICACHE_EN.
- Defined:
  - Instantiates a direct-mapped icache of ICACHE_LINES words: index pc[log2(L)+1:2], tag pc[31:log2(L)+2], per-line valid bit. All valid bits are cleared on rst.
  - In IDLE and at every HOLD handoff, the next pc is looked up.
  - Hit: go directly to HOLD with inst_valid_o=1 next cycle, no bus request.
  - Miss: normal FETCH. On completion of the 4th byte, the line is written.
  - A jump during a fill aborts the fill; the line is not written.
- Undefined: no cache storage; every instruction uses FETCH.

Decomposition:
- config.v gains IF state encodings (`IF_IDLE`, `IF_FETCH`, `IF_HOLD`) and `ICacheLines`. Existing `AddrLen`, `InstLen`, `ZeroWord` are reused.
- One sub-module, icache, instantiated only under ICACHE_EN. Ports: lookup address and hit/data; write enable, address and data.

Test Plan:
- Reset, grant always 1, memory [0..3]=13 05 50 00: inst_valid_o first high 6 cycles after reset release, pc_o=0, inst_o=0x00500513, mem_addr_o sequence 0,1,2,3.
- mem_gnt_i low for 3 cycles mid-fetch after byte 1: inst_o still correct, inst_valid_o 3 cycles later, no address repeated or skipped.
- stall_i high for 4 cycles in HOLD: pc_o/inst_o unchanged, mem_req_o=0. After release, next fetch starts at pc=4.
- jump_i with jump_addr_i=0x103 during byte-2 grant: the byte arriving next cycle is ignored, next fetch addresses 0x100..0x103, pc_o=0x100.
- jump_i and stall_i=0 together in HOLD: held instruction dropped (no handoff), pc=target. rst asserted mid-FETCH: state IDLE, inst_valid_o=0, pc=RESET_PC.
- ICACHE_EN: loop back to pc 0 after first fill: inst_valid_o 1 cycle after IDLE, zero mem_req_o cycles. After rst, the same pc misses.
